// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: ALU operation codes (also used by
// the ALU decoder) and the state encoding of the multi-cycle ALU.
package mips_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: low WIDTH bits of an unsigned a*b.
// start loads the operands; WIDTH steps follow, one per cycle. done is high
// during the cycle whose closing edge performs the last step, and product
// shows that step's outcome, so the caller can capture it on the same edge.
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;
  logic             busy;

  // Accumulator value after the step taken at the next edge.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  assign product = acc_next;
  assign done    = busy && (cnt == LAST);

  // Operand load on start, then one shift-add step per cycle while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (cnt == LAST) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/and/or/slt, iterative mul.
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. in_ready
// is high only in IDLE; out_valid is high only in DONE, where result, zero and
// illegal hold steady until the consumer takes them.
module alu_mc
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucontrol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output alu_state_t       dbg_state
);

  alu_state_t       state;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] comb_res;
  logic             comb_ill;
  logic [WIDTH:0]   diff;

  assign in_ready  = (state == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (alucontrol == ALU_MUL);
  assign dbg_state = state;

  // Sign-extended difference: its top bit is a<b even when a-b overflows.
  assign diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};

  // Single-cycle datapath; unsupported codes give 0 and flag illegal.
  always_comb begin
    comb_res = '0;
    comb_ill = 1'b0;
    case (alucontrol)
      ALU_ADD: comb_res = a + b;
      ALU_SUB: comb_res = a - b;
      ALU_AND: comb_res = a & b;
      ALU_OR:  comb_res = a | b;
      ALU_SLT: comb_res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
      ALU_MUL: comb_res = '0;
      default: comb_ill = 1'b1;
    endcase
  end

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (alucontrol == ALU_MUL) begin
              state <= S_MUL;
            end else begin
              result    <= comb_res;
              zero      <= (comb_res == '0);
              illegal   <= comb_ill;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_MUL: begin
          if (mul_done) begin
            result    <= mul_product;
            zero      <= (mul_product == '0);
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed vector table, hand-written reset-abort sequence,
// and random operations checked against an arithmetic reference model.
module tb_alu_mc;
  import mips_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   alucontrol;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;
  alu_state_t   dbg_state;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .alucontrol (alucontrol),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal),
    .dbg_state  (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model from the operation definitions.
  task automatic model(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic ill);
    ill = 1'b0;
    case (c)
      3'b010:  r = x + y;
      3'b110:  r = x - y;
      3'b000:  r = x & y;
      3'b001:  r = x | y;
      3'b111:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'b011:  r = x * y;
      default: begin r = '0; ill = 1'b1; end
    endcase
  endtask

  // ---------------- driver ----------------
  // Issue one request, measure latency, check the result, hold DONE for
  // 'hold' cycles with noise on the inputs, then release it.
  task automatic run_op(input string tag, input logic [2:0] c, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] er, input logic ez,
                        input logic ei, input int elat, input int hold);
    int lat;
    int early;
    bit seen;
    @(negedge clk);
    for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; a = x; b = y; alucontrol = c;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; alucontrol = 3'($urandom_range(0, 7));
    lat = 0; early = 0; seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
      else if (in_ready || zero || illegal) early++;
    end
    chk({tag, ".busy_flags"}, 64'(early), 64'd0);
    chk({tag, ".latency"}, 64'(lat), 64'(elat));
    chk({tag, ".result"}, 64'(result), 64'(er));
    chk({tag, ".zero"}, 64'(zero), 64'(ez));
    chk({tag, ".illegal"}, 64'(illegal), 64'(ei));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
      alucontrol = 3'($urandom_range(0, 7));
      @(negedge clk);
      chk({tag, ".hold_result"}, 64'(result), 64'(er));
      chk({tag, ".hold_hs"}, 64'({out_valid, in_ready, zero, illegal}), 64'({2'b10, ez, ei}));
    end
    // A request offered on the release edge must not be taken.
    out_ready = 1'b1; in_valid = 1'b1; alucontrol = 3'b010;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".release"}, 64'({out_valid, in_ready, zero, illegal}), 64'b0100);
    chk({tag, ".state"}, 64'(dbg_state), 64'(S_IDLE));
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [2:0]   code;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic         exp_zero;
    logic         exp_ill;
    int           exp_lat;
    int           hold;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [2:0]   c;
    logic [W-1:0] x, y, er;
    logic         ei;

    vecs[0]  = '{3'b010, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, 1,  0};
    vecs[1]  = '{3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 1,  0};
    vecs[2]  = '{3'b110, 32'h5,         32'h5,         32'h0,         1'b1, 1'b0, 1,  5};
    vecs[3]  = '{3'b011, 32'h0001_2345, 32'h0001_0000, 32'h2345_0000, 1'b0, 1'b0, 33, 0};
    vecs[4]  = '{3'b100, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0,         1'b1, 1'b1, 1,  0};
    vecs[5]  = '{3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1,  0};
    vecs[6]  = '{3'b001, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 1'b0, 1,  0};
    vecs[7]  = '{3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0,         1'b1, 1'b0, 1,  0};
    vecs[8]  = '{3'b101, 32'h0,         32'h0,         32'h0,         1'b1, 1'b1, 1,  2};
    vecs[9]  = '{3'b110, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1'b0, 1,  0};
    vecs[10] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 33, 3};
    vecs[11] = '{3'b011, 32'h0,         32'hDEAD_BEEF, 32'h0,         1'b1, 1'b0, 33, 0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; alucontrol = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.outs", 64'({out_valid, in_ready, zero, illegal}), 64'b0100);
    chk("reset.result", 64'(result), 64'd0);
    chk("reset.state", 64'(dbg_state), 64'(S_IDLE));
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].exp_res,
             vecs[i].exp_zero, vecs[i].exp_ill, vecs[i].exp_lat, vecs[i].hold);

    // Reset in the middle of a multiply aborts it.
    @(negedge clk);
    in_valid = 1'b1; a = 32'h0001_2345; b = 32'h0001_0000; alucontrol = 3'b011;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("rst_mul.state_before", 64'(dbg_state), 64'(S_MUL));
    reset = 1'b1;
    #1;
    chk("rst_mul.outs", 64'({out_valid, in_ready, zero, illegal}), 64'b0100);
    chk("rst_mul.result", 64'(result), 64'd0);
    chk("rst_mul.state", 64'(dbg_state), 64'(S_IDLE));
    @(negedge clk);
    reset = 1'b0;
    run_op("rst_add", 3'b010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, 0);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      c = 3'($urandom_range(0, 7));
      x = (i % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      y = (i % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if (i % 8 == 1) y = x;
      model(c, x, y, er, ei);
      run_op($sformatf("rnd%0d", i), c, x, y, er, (er == '0), ei,
             (c == 3'b011) ? 33 : 1, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 The block SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 The block SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port: in_valid  input  1  operation request present.
REQ-005 The block SHALL have port: in_ready  output  1  block can accept a request.
REQ-006 The block SHALL have ports: a, b  input  WIDTH  operands.
REQ-007 The block SHALL have port: alucontrol  input  3  operation code from the ALU decoder.
REQ-008 The block SHALL have port: out_valid  output  1  result present.
REQ-009 The block SHALL have port: out_ready  input  1  consumer takes the result.
REQ-010 The block SHALL have port: result  output  WIDTH  operation result.
REQ-011 The block SHALL have port: zero  output  1  result == 0.
REQ-012 The block SHALL have port: illegal  output  1  the accepted code was unsupported.

Function
REQ-013 The block SHALL implement alucontrol codes: 010 add; 110 sub (a-b); 000 and; 001 or; 111 slt (signed a<b -> 1, else 0); 011 mul (low WIDTH bits of a*b, unsigned).
REQ-014 The block SHALL treat codes 100 and 101 as illegal: result 0, zero 1, illegal 1, single-cycle timing.
REQ-015 The block SHALL wrap add/sub modulo 2^WIDTH, with no overflow flag.
REQ-016 The block SHALL compute slt from the sign of the WIDTH+1-bit difference, so that it is correct across signed overflow.
REQ-017 The block SHALL have FSM states IDLE, MUL and DONE.
REQ-018 The block SHALL hold in_ready = 1 only in IDLE; a request is accepted when in_valid && in_ready.
REQ-019 On acceptance of a non-mul code in IDLE, the block SHALL register the result and go to DONE; out_valid is asserted the next cycle (latency 1).
REQ-020 On acceptance of mul, the block SHALL latch a and b and go to MUL, performing one shift-add step per cycle for WIDTH cycles and then go to DONE; out_valid is asserted WIDTH+1 cycles after acceptance.
REQ-021 In DONE, the block SHALL hold out_valid = 1 and keep result/zero/illegal stable until out_ready = 1, then go to IDLE.
REQ-022 The block SHALL NOT accept a request in the cycle DONE exits, since in_ready = 0 in DONE.
REQ-023 The block SHALL ignore operand and alucontrol changes after acceptance.
REQ-024 The block SHALL hold zero and illegal at 0 whenever out_valid = 0.

Reset
REQ-025 Reset SHALL asynchronously force state IDLE, out_valid 0, result 0, zero 0, illegal 0, and clear the multiplier registers and iteration counter.
REQ-026 Reset asserted in MUL or DONE SHALL abort the operation and discard its result; the first request after reset release SHALL be accepted normally.

Structure
REQ-027 The alucontrol code constants SHALL live in a shared package (mips_pkg), also used by the ALU decoder.
REQ-028 The FSM state enumeration SHALL live in the same package.
REQ-029 The iterative multiplier SHALL be a sub-module named mul_iter, with start/done and its own counter of width clog2(WIDTH)+1; the FSM and single-cycle datapath SHALL stay in alu_mc.

Verification
REQ-030 The bench SHALL cover: add a=0xFFFFFFFF, b=1 -> result 0x00000000, zero 1, out_valid one cycle after accept.
REQ-031 The bench SHALL cover: slt a=0x80000000, b=0x7FFFFFFF -> result 1; and a=5, b=5 with sub -> result 0, zero 1.
REQ-032 The bench SHALL cover: mul a=0x00012345, b=0x00010000 -> result 0x23450000, out_valid exactly 33 cycles after accept, in_ready low throughout.
REQ-033 The bench SHALL cover: out_ready held 0 for 5 cycles in DONE -> result stable, in_valid pulses ignored; out_ready 1 -> IDLE the next cycle.
REQ-034 The bench SHALL cover: code 100 -> result 0, illegal 1, zero 1; a following and 0xF0F0, 0xFF00 -> result 0xF000, illegal 0.
REQ-035 The bench SHALL cover: reset asserted at mul iteration 10 -> out_valid 0 immediately; the next add 2+3 gives result 5 with latency 1.
